alu_cmd_issuer: RTL and testbench

//  Initiator side of the ALU interface: accepts op requests over valid/ready, drives sel/number1/number2 to the

---
 rtl/alu_cmd_issuer.sv | 160 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts requests, screens illegal ops / divide-by-zero, drives a registered ALU,
// waits its latency and returns the result over valid/ready. Optional counters: ALU_ISSUER_STATS_EN.
module alu_cmd_issuer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RES_W       = 16,
  parameter int unsigned ALU_LATENCY = 1
`ifdef ALU_ISSUER_STATS_EN
  , parameter int unsigned STAT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] alu_number1,
  output logic [DATA_W-1:0] alu_number2,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err
`ifdef ALU_ISSUER_STATS_EN
  , output logic [STAT_W-1:0] stat_ops
  , output logic [STAT_W-1:0] stat_errs
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b100;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_req_ready;
  logic [2:0]        r_alu_sel;
  logic [DATA_W-1:0] r_alu_n1;
  logic [DATA_W-1:0] r_alu_n2;
  logic              r_rsp_valid;
  logic [RES_W-1:0]  r_rsp_data;
  logic              r_rsp_err;

  logic w_accept;
  logic w_legal;
  logic w_div0;
  logic w_rsp_hs;

  always_comb begin
    w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;
    w_legal  = (req_op >= OP_ADD) && (req_op <= OP_DIV);
    w_div0   = (req_op == OP_DIV) && (req_b == '0);
    w_rsp_hs = (r_state == S_RESP) && r_rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_alu_sel   <= '0;
      r_alu_n1    <= '0;
      r_alu_n2    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            // Screened requests skip the ALU entirely and answer on the next edge.
            if (!w_legal) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_div0) begin
              r_rsp_data  <= '1;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_alu_sel <= req_op;
              r_alu_n1  <= req_a;
              r_alu_n2  <= req_b;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= CNT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= alu_result;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_alu_sel   <= '0;
            r_alu_n1    <= '0;
            r_alu_n2    <= '0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  logic [STAT_W-1:0] r_stat_ops;
  logic [STAT_W-1:0] r_stat_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops  <= '0;
      r_stat_errs <= '0;
    end else if (w_rsp_hs) begin
      r_stat_ops <= r_stat_ops + 1'b1;
      if (r_rsp_err) begin
        r_stat_errs <= r_stat_errs + 1'b1;
      end
    end
  end

  assign stat_ops  = r_stat_ops;
  assign stat_errs = r_stat_errs;
`endif

  assign req_ready   = r_req_ready;
  assign alu_sel     = r_alu_sel;
  assign alu_number1 = r_alu_n1;
  assign alu_number2 = r_alu_n2;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench for alu_cmd_issuer with a registered 1-cycle ALU model attached.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_number1;
  logic [7:0]  alu_number2;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  alu_cmd_issuer #(.DATA_W(8), .RES_W(16), .ALU_LATENCY(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_sel     (alu_sel),
    .alu_number1 (alu_number1),
    .alu_number2 (alu_number2),
    .alu_result  (alu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
`ifdef ALU_ISSUER_STATS_EN
    , .stat_ops  (stat_ops)
    , .stat_errs (stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: result available one edge after operands are presented.
  always_ff @(posedge clk) begin
    case (alu_sel)
      3'b001:  alu_result <= {8'h00, alu_number1} + {8'h00, alu_number2};
      3'b010:  alu_result <= {8'h00, alu_number1} - {8'h00, alu_number2};
      3'b011:  alu_result <= alu_number1 * alu_number2;
      3'b100:  alu_result <= (alu_number2 != 8'h00) ? {8'h00, alu_number1 / alu_number2} : 16'hFFFF;
      default: alu_result <= 16'h0000;
    endcase
  end

  // Called at a negedge; returns at the negedge following the accept edge with garbage on req_*.
  task automatic send_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'b011;
    req_a     = 8'h5A;
    req_b     = 8'hC3;
  endtask

  // Edges counted from the accept edge inclusive until rsp_valid is seen; 20 means timed out.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'b000; req_a = 8'h00; req_b = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if ({alu_sel, alu_number1, alu_number2} !== 19'h0) begin errors++;
      $display("FAIL reset_alu got sel %b n1 %h n2 %h exp all 0", alu_sel, alu_number1, alu_number2); end
`ifdef ALU_ISSUER_STATS_EN
    checks++; if ({stat_ops, stat_errs} !== 32'h0) begin errors++;
      $display("FAIL reset_stats got ops %0d errs %0d exp 0 0", stat_ops, stat_errs); end
`endif
  endtask

  task automatic test_add;
    int n;
    rsp_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready_idle got %b exp 1", req_ready); end
    send_req(3'b001, 8'd200, 8'd100);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL add_ready_busy got %b exp 0", req_ready); end
    checks++; if ({alu_sel, alu_number1, alu_number2} !== {3'b001, 8'd200, 8'd100}) begin errors++;
      $display("FAIL add_issue got sel %b n1 %0d n2 %0d exp 001 200 100", alu_sel, alu_number1, alu_number2); end
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", n); end
    checks++; if (rsp_data !== 16'h012C) begin errors++; $display("FAIL add_data got %h exp 012c", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", rsp_err); end
    checks++; if (alu_sel !== 3'b000) begin errors++; $display("FAIL add_sel_cleared got %b exp 000", alu_sel); end
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++;
      $display("FAIL add_handshake got valid %b ready %b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    int n;
    rsp_ready = 1'b1;
    send_req(3'b011, 8'd255, 8'd255);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b exp 0", req_ready); end
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_mul_latency got %0d exp 3", n); end
    checks++; if (rsp_data !== 16'hFE01) begin errors++; $display("FAIL b2b_mul_data got %h exp fe01", rsp_data); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp got %b exp 0", req_ready); end
    // Present the next request during the response handshake cycle: it must not be taken there.
    req_op = 3'b010; req_a = 8'd5; req_b = 8'd7; req_valid = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready, alu_sel} !== {1'b0, 1'b1, 3'b000}) begin errors++;
      $display("FAIL b2b_no_overlap got valid %b ready %b sel %b exp 0 1 000", rsp_valid, req_ready, alu_sel); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = 8'hEE; req_b = 8'h01;
    checks++; if (alu_sel !== 3'b010) begin errors++; $display("FAIL b2b_sub_issue got %b exp 010", alu_sel); end
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_sub_latency got %0d exp 3", n); end
    checks++; if (rsp_data !== 16'hFFFE) begin errors++; $display("FAIL b2b_sub_data got %h exp fffe", rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_div0;
    int n;
    rsp_ready = 1'b0;
    send_req(3'b100, 8'd7, 8'd0);
    wait_rsp(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", n); end
    checks++; if ({rsp_data, rsp_err} !== {16'hFFFF, 1'b1}) begin errors++;
      $display("FAIL div0_rsp got data %h err %b exp ffff 1", rsp_data, rsp_err); end
    checks++; if (alu_sel !== 3'b000) begin errors++; $display("FAIL div0_sel_resp got %b exp 000", alu_sel); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, alu_sel} !== 4'b0000) begin errors++;
      $display("FAIL div0_after got valid %b sel %b exp 0 000", rsp_valid, alu_sel); end
  endtask

  task automatic test_illegal;
    int n;
    rsp_ready = 1'b1;
    send_req(3'b111, 8'd1, 8'd1);
    wait_rsp(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", n); end
    checks++; if ({rsp_data, rsp_err, alu_sel} !== {16'h0000, 1'b1, 3'b000}) begin errors++;
      $display("FAIL illegal_rsp got data %h err %b sel %b exp 0000 1 000", rsp_data, rsp_err, alu_sel); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int n;
    rsp_ready = 1'b1;
    send_req(3'b100, 8'd100, 8'd7);
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL div_latency got %0d exp 3", n); end
    checks++; if ({rsp_data, rsp_err} !== {16'd14, 1'b0}) begin errors++;
      $display("FAIL div_rsp got data %0d err %b exp 14 0", rsp_data, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n;
    rsp_ready = 1'b0;
    send_req(3'b001, 8'd1, 8'd1);
    wait_rsp(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_data, rsp_err, req_ready} !== {1'b1, 16'd2, 1'b0, 1'b0}) begin errors++;
        $display("FAIL bp_hold[%0d] got valid %b data %h err %b ready %b exp 1 0002 0 0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++;
      $display("FAIL bp_release got valid %b ready %b exp 0 1", rsp_valid, req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single got %b exp 0", rsp_valid); end
  endtask

`ifdef ALU_ISSUER_STATS_EN
  task automatic test_stats;
    // Handshakes so far: add, mul, sub, div0(err), illegal(err), div, add -> 7 ops, 2 errors.
    checks++; if ({stat_ops, stat_errs} !== {16'd7, 16'd2}) begin errors++;
      $display("FAIL stats got ops %0d errs %0d exp 7 2", stat_ops, stat_errs); end
  endtask
`endif

  task automatic test_reset_wait;
    rsp_ready = 1'b1;
    send_req(3'b001, 8'd3, 8'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({req_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin errors++;
      $display("FAIL rstw_rsp got ready %b valid %b err %b data %h exp 1 0 0 0000", req_ready, rsp_valid, rsp_err, rsp_data); end
    checks++; if ({alu_sel, alu_number1, alu_number2} !== 19'h0) begin errors++;
      $display("FAIL rstw_alu got sel %b n1 %h n2 %h exp all 0", alu_sel, alu_number1, alu_number2); end
`ifdef ALU_ISSUER_STATS_EN
    checks++; if ({stat_ops, stat_errs} !== 32'h0) begin errors++;
      $display("FAIL rstw_stats got ops %0d errs %0d exp 0 0", stat_ops, stat_errs); end
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_rsp[%0d] got %b exp 0", i, rsp_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_div0;
    test_illegal;
    test_div;
    test_backpressure;
`ifdef ALU_ISSUER_STATS_EN
    test_stats;
`endif
    test_reset_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
